// File: rtl/slc3_run_ctrl_if.sv
// CPU-side signals of the SLC-3 run controller: pause request/code in,
// clear/start/continue pulses, LED latch and FSM state out.
interface slc3_run_ctrl_if;
    logic       pause_req;
    logic [9:0] pause_code;
    logic       cpu_clear;
    logic       cpu_start;
    logic       cpu_continue;
    logic [9:0] LED;
    logic [1:0] state;

    modport master (
        output pause_req, pause_code,
        input  cpu_clear, cpu_start, cpu_continue, LED, state
    );

    modport slave (
        input  pause_req, pause_code,
        output cpu_clear, cpu_start, cpu_continue, LED, state
    );
endinterface

// File: rtl/slc3_run_ctrl.sv
// SLC-3 run/pause controller: synchronizes and edge-detects Run/Continue buttons and
// sequences clear/start/continue pulses. Define SLC3_CTRL_DEBOUNCE_EN to include the debouncer.
//
// state   | meaning
// IDLE    | after reset or a combined Run+Continue clear; CPU not started
// RUNNING | CPU executing
// PAUSED  | PAUSE instruction seen, LED holds its code, waiting for Continue
// RESUME  | continue pulse issued, waiting for pause_req to drop
module slc3_run_ctrl #(
    parameter int DB_CYCLES = 4
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Run,
    input  logic           Continue,
    slc3_run_ctrl_if.slave cpu
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_RESUME  = 2'd3
    } state_t;

    // Bit 0 is Run, bit 1 is Continue; both active-low.
    logic [1:0] btn;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] db_lvl;
    logic [1:0] lvl_prev_q;
    logic [1:0] press_q;

    assign btn = {Continue, Run};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

`ifdef SLC3_CTRL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q [2];
    logic [1:0]       db_q;

    // Accept the new level on the DB_CYCLES-th consecutive differing sample.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            db_q     <= '1;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= CNT_W'(DB_CYCLES - 1)) begin
                    db_q[i]  <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign db_lvl = db_q;
`else
    assign db_lvl = sync2_q;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lvl_prev_q <= '1;
            press_q    <= '0;
        end else begin
            lvl_prev_q <= db_lvl;
            press_q    <= lvl_prev_q & ~db_lvl;
        end
    end

    logic run_ev, cont_ev;
    assign run_ev  = press_q[0];
    assign cont_ev = press_q[1];

    state_t     state_q, state_d;
    logic       pend_q, pend_d;
    logic       clr_q, clr_d;
    logic       start_q, start_d;
    logic       cont_q, cont_d;
    logic [9:0] led_q, led_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            clr_q   <= 1'b0;
            start_q <= 1'b0;
            cont_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            clr_q   <= clr_d;
            start_q <= start_d;
            cont_q  <= cont_d;
            led_q   <= led_d;
        end
    end

    // A Run press always wins and restarts the clear/start sequence.
    always_comb begin
        state_d = state_q;
        pend_d  = 1'b0;
        clr_d   = 1'b0;
        start_d = 1'b0;
        cont_d  = 1'b0;
        led_d   = led_q;
        if (run_ev) begin
            clr_d   = 1'b1;
            pend_d  = ~cont_ev;
            state_d = ST_IDLE;
        end else if (pend_q) begin
            start_d = 1'b1;
            state_d = ST_RUNNING;
        end else begin
            case (state_q)
                ST_RUNNING: if (cpu.pause_req) begin
                    state_d = ST_PAUSED;
                    led_d   = cpu.pause_code;
                end
                ST_PAUSED: if (cont_ev) begin
                    cont_d  = 1'b1;
                    state_d = ST_RESUME;
                end
                ST_RESUME: if (!cpu.pause_req) state_d = ST_RUNNING;
                default: ;
            endcase
        end
    end

    assign cpu.cpu_clear    = clr_q;
    assign cpu.cpu_start    = start_q;
    assign cpu.cpu_continue = cont_q;
    assign cpu.LED          = led_q;
    assign cpu.state        = state_q;

endmodule

// File: doc/slc3_run_ctrl.md
SLC3_RUN_CTRL -- requirements
Module: slc3_run_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4: consecutive stable cycles needed to accept a button level change.
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state on the rising edge.
REQ-003 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Run, input, 1 bit: active-low push button, asynchronous to Clk.
REQ-005 SHALL have port Continue, input, 1 bit: active-low push button, asynchronous to Clk.
REQ-006 SHALL have port pause_req, input, 1 bit: level from the CPU control unit, high while a PAUSE instruction is executing.
REQ-007 SHALL have port pause_code, input, 10 bits: IR[9:0] of the pausing instruction.
REQ-008 SHALL have port cpu_clear, output, 1 bit: one-cycle synchronous clear pulse to the datapath.
REQ-009 SHALL have port cpu_start, output, 1 bit: one-cycle start pulse to the control unit.
REQ-010 SHALL have port cpu_continue, output, 1 bit: one-cycle resume pulse to the control unit.
REQ-011 SHALL have port LED, output, 10 bits: latched pause code.
REQ-012 SHALL have port state, output, 2 bits: IDLE=0, RUNNING=1, PAUSED=2, RESUME=3.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then the debouncer, then a falling-edge detector that yields a 1-cycle press event.
REQ-014 The debounced level SHALL change only after the synchronized sample differs from it for DB_CYCLES consecutive cycles; the counter SHALL clear on any matching sample.
REQ-015 Run press in any state with no Continue press in the same cycle SHALL pulse cpu_clear next cycle, pulse cpu_start the cycle after, and enter RUNNING together with the cpu_start pulse.
REQ-016 Run and Continue press events in the same cycle SHALL pulse cpu_clear only and enter IDLE.
REQ-017 In RUNNING, pause_req=1 SHALL enter PAUSED next cycle and latch LED<=pause_code in that same edge.
REQ-018 In PAUSED, a Continue press SHALL pulse cpu_continue for exactly one cycle and enter RESUME.
REQ-019 In RESUME, the FSM SHALL stay until pause_req=0, then enter RUNNING; LED SHALL hold its value.
REQ-020 A Continue press in IDLE, RUNNING or RESUME SHALL be ignored.
REQ-021 cpu_clear, cpu_start and cpu_continue SHALL be mutually exclusive; no pulse SHALL last more than one cycle.
REQ-022 A held button SHALL generate exactly one press event; release SHALL generate none.
REQ-023 The debounce counter SHALL be sized ceil(log2(DB_CYCLES+1)) bits and SHALL saturate, never wrap.
REQ-024 A Run press arriving during the clear/start sequence SHALL restart the sequence from cpu_clear.

Reset
REQ-025 Reset_n=0 SHALL asynchronously force state=IDLE, LED=0, all pulse outputs 0, synchronizer and debounced levels 1 (released), and debounce counters 0.
REQ-026 After Reset_n deasserts, a button already held low SHALL generate one press event once it is accepted.
REQ-027 Reset mid-sequence SHALL abort any pending pulse; no pulse SHALL follow reset release without a new press.

Configuration
REQ-028 With macro SLC3_CTRL_DEBOUNCE_EN defined, the debouncer SHALL be present, and press-to-first-pulse latency SHALL be 4+DB_CYCLES cycles.
REQ-029 With SLC3_CTRL_DEBOUNCE_EN undefined, the debounced level SHALL equal the synchronizer output, and latency SHALL be exactly 4 cycles; all other behaviour is unchanged.

Verification
REQ-030 Macro off, reset, Run low for 2 cycles -> cpu_clear at cycle 4, cpu_start at cycle 5, state=1.
REQ-031 RUNNING, pause_req=1 with pause_code=10'h2A5 -> next cycle state=2, LED=10'h2A5; a Continue press -> one cpu_continue pulse, state=3; pause_req=0 -> state=1.
REQ-032 Macro on, DB_CYCLES=4, Run glitches low for 3 cycles -> no pulses; Run low for 6 cycles -> cpu_clear at cycle 8.
REQ-033 Run and Continue fall on the same edge while PAUSED -> single cpu_clear, no cpu_start, state=0, LED unchanged.
REQ-034 Continue press while RUNNING, then Continue held for 50 cycles while PAUSED -> first ignored; exactly one cpu_continue.
REQ-035 Reset_n low for 1 cycle between the cpu_clear and cpu_start pulses -> state=0, no cpu_start, LED=0.
